// File: rtl/bus_pkg.sv
// Shared definitions for the two-master round-robin bus arbiter.
//   NumMasters : number of requesting masters
//   state_e    : arbiter state encoding (2 bits, all four codes used)
//   arb()      : arbitration decision used from idle and at the end of turnaround
package bus_pkg;

    localparam int unsigned NumMasters = 2;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGnt0 = 2'b01,
        StGnt1 = 2'b10,
        StTurn = 2'b11
    } state_e;

    // On a tie, grant the master that did not own the bus last time.
    function automatic state_e arb(input logic [NumMasters-1:0] req, input logic last);
        state_e res;
        case (req)
            2'b01:   res = StGnt0;
            2'b10:   res = StGnt1;
            2'b11:   res = last ? StGnt0 : StGnt1;
            default: res = StIdle;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
//   Req : one request line per master
//   Ack : one-hot (or zero) registered grant per master
//   master modport : requester side (drives Req, observes Ack)
//   slave  modport : arbiter side (observes Req, drives Ack)
interface bus_arbiter_if;
    import bus_pkg::*;

    logic [NumMasters-1:0] Req;
    logic [NumMasters-1:0] Ack;

    modport master (output Req, input Ack);
    modport slave  (input Req, output Ack);

endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with registered grant, round-robin tie breaking and a
// DELAY-cycle dead gap after each grant release.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : request/grant bundle (slave side)
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned DELAY = 2
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter_if.slave   bus
);

    localparam int unsigned CntW = (DELAY == 0) ? 1 : $clog2(DELAY + 1);
    localparam logic [CntW-1:0] CntLoad = (DELAY > 0) ? CntW'(DELAY - 1) : '0;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;  // index of the master granted most recently

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;  // master 0 wins the first tie
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                state_d = arb(bus.Req, last_q);
            end
            StGnt0: begin
                if (!bus.Req[0]) begin
                    last_d = 1'b0;
                    if (DELAY > 0) begin
                        state_d = StTurn;
                        cnt_d   = CntLoad;
                    end else begin
                        // No gap: the other master may be granted on this same edge.
                        state_d = arb(bus.Req, 1'b0);
                    end
                end
            end
            StGnt1: begin
                if (!bus.Req[1]) begin
                    last_d = 1'b1;
                    if (DELAY > 0) begin
                        state_d = StTurn;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = arb(bus.Req, 1'b1);
                    end
                end
            end
            StTurn: begin
                // Requests are only looked at once the gap has fully elapsed.
                if (cnt_q == '0) begin
                    state_d = arb(bus.Req, last_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant is a pure decode of the state register, so Req never reaches Ack
    // combinationally.
    always_comb begin
        bus.Ack = '0;
        unique case (state_q)
            StGnt0:  bus.Ack = 2'b01;
            StGnt1:  bus.Ack = 2'b10;
            default: bus.Ack = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic clk;
    logic reset;

    bus_arbiter_if bus2 ();
    bus_arbiter_if bus0 ();

    bus_arbiter #(.DELAY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    bus_arbiter #(.DELAY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic [1:0] ack;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_miss;

    function automatic vec_t mk(logic r, logic [1:0] q, logic [1:0] a, string n);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.ack   = a;
        v.name  = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: Ack=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs sampled at that same point.
    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset     = 1'b0;
        bus2.Req  = 2'b11;
        bus0.Req  = 2'b00;

        // DELAY=2 instance, hand-computed sequence.
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, "rst_hold0"));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, "rst_hold1"));
        vecs.push_back(mk(1'b1, 2'b11, 2'b01, "first_tie_to0"));
        vecs.push_back(mk(1'b1, 2'b01, 2'b01, "hold0"));
        vecs.push_back(mk(1'b1, 2'b11, 2'b01, "no_preempt"));
        vecs.push_back(mk(1'b1, 2'b10, 2'b00, "turn0_a"));
        vecs.push_back(mk(1'b1, 2'b10, 2'b00, "turn0_b"));
        vecs.push_back(mk(1'b1, 2'b10, 2'b10, "handover_to1"));
        vecs.push_back(mk(1'b1, 2'b11, 2'b10, "hold1"));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, "rel1_turn_a"));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, "rel1_turn_b"));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, "idle_a"));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, "idle_b"));
        vecs.push_back(mk(1'b1, 2'b10, 2'b10, "idle_to1"));
        vecs.push_back(mk(1'b1, 2'b01, 2'b00, "rr_turn_a"));
        vecs.push_back(mk(1'b1, 2'b11, 2'b00, "rr_turn_b"));
        vecs.push_back(mk(1'b1, 2'b11, 2'b01, "rr_tie_to0"));
        vecs.push_back(mk(1'b1, 2'b10, 2'b00, "rr2_turn_a"));
        vecs.push_back(mk(1'b1, 2'b11, 2'b00, "rr2_turn_b"));
        vecs.push_back(mk(1'b1, 2'b11, 2'b10, "rr_tie_to1"));
        vecs.push_back(mk(1'b1, 2'b01, 2'b00, "late_turn_a"));
        vecs.push_back(mk(1'b1, 2'b01, 2'b00, "late_turn_b"));
        vecs.push_back(mk(1'b1, 2'b01, 2'b01, "late_req_to0"));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, "rel0_turn_a"));
        vecs.push_back(mk(1'b1, 2'b10, 2'b00, "rel0_turn_b"));
        vecs.push_back(mk(1'b1, 2'b10, 2'b10, "to1_again"));

        #1;
        check("rst_async_init", bus2.Ack, 2'b00);
        check("rst_async_init_d0", bus0.Ack, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst_n;
            bus2.Req = vecs[i].req;
            edge_sample();
            check(vecs[i].name, bus2.Ack, vecs[i].ack);
        end

        // Asynchronous reset mid-grant: Ack must drop with no clock edge.
        #2;
        check("pre_async_rst", bus2.Ack, 2'b10);
        reset = 1'b0;
        #1;
        check("async_rst_drop", bus2.Ack, 2'b00);
        bus2.Req = 2'b11;
        edge_sample();
        check("async_rst_hold", bus2.Ack, 2'b00);
        reset = 1'b1;
        edge_sample();
        check("post_rst_tie_to0", bus2.Ack, 2'b01);
        bus2.Req = 2'b00;
        edge_sample();
        check("post_rst_rel", bus2.Ack, 2'b00);

        // DELAY=0 instance: handover with no dead cycle.
        bus0.Req = 2'b01;
        edge_sample();
        check("d0_grant0", bus0.Ack, 2'b01);
        bus0.Req = 2'b11;
        edge_sample();
        check("d0_hold0", bus0.Ack, 2'b01);
        bus0.Req = 2'b10;
        edge_sample();
        check("d0_direct_to1", bus0.Ack, 2'b10);
        bus0.Req = 2'b01;
        edge_sample();
        check("d0_direct_to0", bus0.Ack, 2'b01);
        bus0.Req = 2'b00;
        edge_sample();
        check("d0_idle", bus0.Ack, 2'b00);
        bus0.Req = 2'b11;
        edge_sample();
        check("d0_tie_to1", bus0.Ack, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
